// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline-register observations and hazard-control outputs
// exchanged between the 5-stage pipeline (master) and pipeline_hazard_ctrl (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_W = 5
);
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic                  ex_mem_read;
  logic                  ex_branch_taken;
  logic [REG_ADDR_W-1:0] mem_rt_or_rd;
  logic                  mem_write_reg;
  logic                  mem_access;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] wb_rt_or_rd;
  logic                  wb_write_reg;

  logic                  pc_stall;
  logic                  if_id_stall;
  logic                  if_id_flush;
  logic                  id_ex_stall;
  logic                  id_ex_flush;
  logic                  ex_mem_stall;
  logic                  mem_wb_bubble;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  mem_err;

  modport master (
    output id_rs, id_rt, ex_rs, ex_rt, ex_mem_read, ex_branch_taken,
           mem_rt_or_rd, mem_write_reg, mem_access, mem_ready,
           wb_rt_or_rd, wb_write_reg,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_bubble, fwd_a, fwd_b, mem_err
  );

  modport slave (
    input  id_rs, id_rt, ex_rs, ex_rt, ex_mem_read, ex_branch_taken,
           mem_rt_or_rd, mem_write_reg, mem_access, mem_ready,
           wb_rt_or_rd, wb_write_reg,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
           ex_mem_stall, mem_wb_bubble, fwd_a, fwd_b, mem_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage pipeline.
// Sequences multi-cycle data-memory waits (RUN/MEM_WAIT) with a timeout
// that drops the access and pulses mem_err.
// Optional macro HAZARD_PERF_CNT_EN adds saturating stall_cycles/flush_count.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned MEM_TIMEOUT = 16
`ifdef HAZARD_PERF_CNT_EN
  , parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0]   stall_cycles,
  output logic [CNT_W-1:0]     flush_count
`endif
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CW-1:0]         CNT_LAST = CW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic [0:0] {RUN, MEM_WAIT} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mem_err_q, mem_err_d;

  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, mem_wb_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic       load_use;

  assign load_use = hz.ex_mem_read && (hz.ex_rt != ZERO_REG) &&
                    ((hz.ex_rt == hz.id_rs) || (hz.ex_rt == hz.id_rt));

  // Next-state, wait counter and all combinational control outputs; everything held at 0 during reset.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_err_d     = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;
    fwd_a         = 2'b00;
    fwd_b         = 2'b00;
    if (!reset) begin
      // EX/MEM is the younger producer, so it takes precedence over MEM/WB.
      if (hz.mem_write_reg && hz.mem_rt_or_rd != ZERO_REG && hz.mem_rt_or_rd == hz.ex_rs)
        fwd_a = 2'b10;
      else if (hz.wb_write_reg && hz.wb_rt_or_rd != ZERO_REG && hz.wb_rt_or_rd == hz.ex_rs)
        fwd_a = 2'b01;
      if (hz.mem_write_reg && hz.mem_rt_or_rd != ZERO_REG && hz.mem_rt_or_rd == hz.ex_rt)
        fwd_b = 2'b10;
      else if (hz.wb_write_reg && hz.wb_rt_or_rd != ZERO_REG && hz.wb_rt_or_rd == hz.ex_rt)
        fwd_b = 2'b01;

      unique case (state_q)
        RUN: begin
          if (hz.mem_access && !hz.mem_ready) begin
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            state_d       = MEM_WAIT;
            cnt_d         = CNT_ONE;
          end else if (hz.ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (hz.mem_ready) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            // The timeout cycle still holds everything; the access is simply abandoned.
            pc_stall      = 1'b1;
            if_id_stall   = 1'b1;
            id_ex_stall   = 1'b1;
            ex_mem_stall  = 1'b1;
            mem_wb_bubble = 1'b1;
            if (cnt_q == CNT_LAST) begin
              state_d   = RUN;
              cnt_d     = '0;
              mem_err_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, wait counter and registered error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RUN;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign hz.pc_stall      = pc_stall;
  assign hz.if_id_stall   = if_id_stall;
  assign hz.if_id_flush   = if_id_flush;
  assign hz.id_ex_stall   = id_ex_stall;
  assign hz.id_ex_flush   = id_ex_flush;
  assign hz.ex_mem_stall  = ex_mem_stall;
  assign hz.mem_wb_bubble = mem_wb_bubble;
  assign hz.fwd_a         = fwd_a;
  assign hz.fwd_b         = fwd_b;
  assign hz.mem_err       = mem_err_q & ~reset;

`ifdef HAZARD_PERF_CNT_EN
  // Saturating counts of PC-stall cycles and ID/EX flush cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (pc_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (id_ex_flush && flush_count != '1)
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule
